mux5_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 5:1 word-select mux in the streaming CGRA between five valid/ready producers.
- Drives the mux's 3-bit select and gates the handshakes, so only the granted input streams to the single output.
- Grants are held for whole bursts, delimited by `last`. A beat limit forces release for fairness.
- Control only: data goes through the external mux, which this block steers.

---
 rtl/mux5_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux5_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter steering a shared 5:1 word mux between five valid/ready producers.
// A grant is held for a whole burst, delimited by last, or capped at MAX_BURST beats.
module mux5_rr_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in_valid,
  input  logic [4:0] in_last,
  output logic [4:0] in_ready,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic [2:0] select,
  output logic [4:0] grant,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t     r_state;
  logic [2:0] r_sel;
  logic [2:0] r_ptr;
  logic [4:0] r_grant;
  logic [7:0] r_cnt;

  logic [7:0] w_valid8;
  logic [7:0] w_last8;
  logic [2:0] w_pick;
  logic       w_busy;
  logic       w_limit;
  logic       w_beat;
  logic [4:0] w_sel_onehot;

  // Padding to 8 bits keeps every 3-bit index in range, even for codes 5..7.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idx = 4'(ptr) + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_valid8     = {3'b000, in_valid};
  assign w_last8      = {3'b000, in_last};
  assign w_pick       = rr_pick(w_valid8, r_ptr);
  assign w_busy       = (r_state == BUSY);
  assign w_limit      = (r_cnt == LAST_CNT);
  assign w_sel_onehot = 5'b00001 << r_sel;

  assign out_valid = w_busy & w_valid8[r_sel];
  assign out_last  = w_busy & (w_last8[r_sel] | w_limit);
  assign in_ready  = (w_busy & out_ready) ? w_sel_onehot : 5'b00000;
  assign w_beat    = out_valid & out_ready;

  assign select = r_sel;
  assign grant  = r_grant;
  assign busy   = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd4;
      r_grant <= 5'b00000;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|in_valid) begin
            r_state <= BUSY;
            r_sel   <= w_pick;
            r_grant <= 5'b00001 << w_pick;
          end
        end
        BUSY: begin
          if (w_beat) begin
            // Last beat, or the beat-limit beat, hands the pointer to the current owner.
            if (out_last) begin
              r_state <= IDLE;
              r_grant <= 5'b00000;
              r_cnt   <= 8'd0;
              r_ptr   <= r_sel;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench for mux5_rr_arbiter: a transaction-level model of the arbitration
// rules is compared every cycle, plus hand-computed literal checks per scenario.
module tb_mux5_rr_arbiter;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] in_valid = '0;
  logic [4:0] in_last = '0;
  logic [4:0] in_ready;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic [2:0] select;
  logic [4:0] grant;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  mux5_rr_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .select(select), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the mux, how many beats it has moved, and who won last.
  int m_busy, m_own, m_sel, m_last_winner, m_beats;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_own = 0; m_sel = 0; m_last_winner = 4; m_beats = 0;
    end else if (m_busy != 0) begin
      if (in_valid[m_own] && out_ready) begin
        m_beats++;
        if (in_last[m_own] || m_beats == MB) begin
          m_busy = 0; m_last_winner = m_own; m_beats = 0;
        end
      end
    end else if (in_valid != 5'b0) begin
      for (int k = 1; k <= 5; k++)
        if (m_busy == 0 && in_valid[(m_last_winner + k) % 5]) begin
          m_busy = 1; m_own = (m_last_winner + k) % 5;
        end
      m_sel = m_own;
    end
  end

  // Observed grant sequence, with the cycle each grant appeared.
  int  g_own[$];
  int  g_cyc[$];
  int  cyc = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    int e_grant, e_ready, e_ov, e_ol;
    cyc++;
    e_grant = (m_busy != 0) ? (1 << m_own) : 0;
    e_ready = (m_busy != 0 && out_ready) ? (1 << m_own) : 0;
    e_ov    = (m_busy != 0 && in_valid[m_own]) ? 1 : 0;
    e_ol    = (m_busy != 0 && (in_last[m_own] || m_beats == MB - 1)) ? 1 : 0;
    chk("grant", int'(grant), e_grant);
    chk("select", int'(select), m_sel);
    chk("busy", int'(busy), m_busy);
    chk("in_ready", int'(in_ready), e_ready);
    chk("out_valid", int'(out_valid), e_ov);
    chk("out_last", int'(out_last), e_ol);
    chk("select_range", int'(select <= 3'd4), 1);
    chk("grant_onehot0", int'($onehot0(grant)), 1);
    chk("in_ready_legal",
        int'(in_ready == 5'b0 || (busy && in_ready == (5'b00001 << select))), 1);
    if (busy && !prev_busy) begin
      g_own.push_back(int'(select));
      g_cyc.push_back(cyc);
    end
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = '0; in_last = '0; out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    int sent2;
    bit b2, b3;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_select", int'(select), 0);
    step(); step();
    rst_n = 1'b1;

    // Single 3-beat burst from input 0.
    in_valid = 5'b00001; in_last = 5'b0; out_ready = 1'b1;
    step();
    chk("t1_select", int'(select), 0);
    chk("t1_grant", int'(grant), 1);
    step(); step();
    in_last = 5'b00001;
    #1;
    chk("t1_last_beat3", int'(out_last), 1);
    step();
    in_valid = '0; in_last = '0;
    #1;
    chk("t1_busy_after", int'(busy), 0);

    // All five request single-beat bursts: strict rotation with one bubble.
    do_reset();
    g_own.delete(); g_cyc.delete();
    in_valid = 5'b11111; in_last = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    in_valid = '0; in_last = '0;
    step();
    chk("t2_ngrants", g_own.size(), 6);
    if (g_own.size() == 6) begin
      chk("t2_g0", g_own[0], 0); chk("t2_g1", g_own[1], 1);
      chk("t2_g2", g_own[2], 2); chk("t2_g3", g_own[3], 3);
      chk("t2_g4", g_own[4], 4); chk("t2_g5", g_own[5], 0);
      for (int i = 1; i < 6; i++) chk("t2_gap", g_cyc[i] - g_cyc[i-1], 2);
    end

    // Input 2 streams 10 beats under a 4-beat cap while input 3 waits.
    do_reset();
    g_own.delete(); g_cyc.delete();
    in_valid = 5'b01100; in_last = 5'b01000; out_ready = 1'b1;
    sent2 = 0;
    for (int i = 0; i < 60 && sent2 < 10; i++) begin
      in_last[2] = (sent2 == 9);
      #1;
      b2 = grant[2] && out_valid && out_ready;
      b3 = grant[3] && out_valid && out_ready;
      if (b2 && sent2 == 2) chk("t3_not_last_beat3", int'(out_last), 0);
      if (b2 && sent2 == 3) chk("t3_forced_last_beat4", int'(out_last), 1);
      step();
      if (b2) sent2++;
      if (b3) in_valid[3] = 1'b0;
    end
    chk("t3_beats_done", sent2, 10);
    in_valid = '0; in_last = '0;
    step();
    chk("t3_ngrants", g_own.size(), 4);
    if (g_own.size() == 4) begin
      chk("t3_g0", g_own[0], 2); chk("t3_g1", g_own[1], 3);
      chk("t3_g2", g_own[2], 2); chk("t3_g3", g_own[3], 2);
    end

    // Input 1 stalled by the consumer for 5 cycles mid-burst.
    do_reset();
    in_valid = 5'b00010; in_last = '0; out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall_ready", int'(in_ready), 0);
      chk("t4_stall_select", int'(select), 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_no_count_in_stall", int'(out_last), 0);
    step();
    #1;
    chk("t4_forced_at_4", int'(out_last), 1);
    step();
    in_valid = '0;
    #1;
    chk("t4_released", int'(busy), 0);

    // Asynchronous reset between edges while input 4 holds the grant.
    do_reset();
    in_valid = 5'b10000; in_last = '0; out_ready = 1'b1;
    step();
    chk("t5_select4", int'(select), 4);
    chk("t5_grant4", int'(grant), 16);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_grant", int'(grant), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_select", int'(select), 0);
    #1 rst_n = 1'b1;
    in_valid = 5'b10001;
    step();
    chk("t5_regrant_select", int'(select), 0);
    chk("t5_regrant_grant", int'(grant), 1);
    in_valid = '0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
